// File: rtl/ex_issue_arbiter_pkg.sv
// Shared ex-stage definitions: FU selector encodings and the issue arbiter state type.
package ex_issue_arbiter_pkg;

  typedef logic [1:0] fu_sel_t;

  localparam fu_sel_t FU_LSU = 2'd0;
  localparam fu_sel_t FU_CSR = 2'd1;
  localparam fu_sel_t FU_ALU = 2'd2;
  localparam fu_sel_t FU_BRU = 2'd3;

  typedef enum logic {
    ARB_IDLE     = 1'b0,
    ARB_CSR_WAIT = 1'b1
  } arb_state_e;

  // Registered issue header handed to the ex stage.
  typedef struct packed {
    logic    valid;
    fu_sel_t fu;
  } issue_hdr_t;

endpackage

// File: rtl/ex_issue_arbiter_oldest_select.sv
// Oldest-first selector: ROB age per entry (modulo ticket width) and min-age pick, one-hot result.
module oldest_select #(
  parameter int N  = 4,
  parameter int TW = 3
) (
  input  logic [N-1:0]    valid,
  input  logic [N*TW-1:0] ticket,
  input  logic [TW-1:0]   head,
  output logic [N-1:0]    onehot,
  output logic            found
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [TW-1:0] age;
  logic [TW-1:0] best_age;
  logic [IW-1:0] best_idx;

  // Strict less-than while scanning upward keeps the lowest index on equal ages.
  always_comb begin
    onehot   = '0;
    found    = 1'b0;
    age      = '0;
    best_age = '0;
    best_idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      age = ticket[i*TW +: TW] - head;
      if (valid[i] && (!found || age < best_age)) begin
        found    = 1'b1;
        best_age = age;
        best_idx = IW'(i);
      end
    end
    if (found) onehot[best_idx] = 1'b1;
  end

endmodule

// File: rtl/ex_issue_arbiter.sv
// Single-slot ex issue arbiter: oldest eligible IQ head, CSR serialisation, registered issue header.
// Optional CSR_WAIT watchdog enabled by defining EX_ARB_CSR_WATCHDOG_EN.
module ex_issue_arbiter
  import ex_issue_arbiter_pkg::*;
#(
  parameter int FU_NUMBER      = 4,
  parameter int ROB_INDEX_BITS = 3,
  parameter int CSR_TIMEOUT    = 16
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                flush,
  input  logic [ROB_INDEX_BITS-1:0]           rob_head,
  input  logic [FU_NUMBER-1:0]                req_valid,
  input  logic [FU_NUMBER*ROB_INDEX_BITS-1:0] req_ticket,
  input  logic [1:0]                          busy_fu,
  input  logic                                csr_done,
  output logic [FU_NUMBER-1:0]                grant,
  output logic                                issue_valid,
  output logic [1:0]                          issue_fu,
  output logic [ROB_INDEX_BITS-1:0]           issue_ticket,
  output logic                                csr_timeout
);

  if (FU_NUMBER < 4) begin : g_bad_fu_number
    $error("ex_issue_arbiter: FU_NUMBER must be at least 4");
  end
  if (CSR_TIMEOUT < 2 || CSR_TIMEOUT > 256) begin : g_bad_timeout
    $error("ex_issue_arbiter: CSR_TIMEOUT must fit the 8-bit watchdog");
  end

  arb_state_e                  state, state_next;
  logic [FU_NUMBER-1:0]        eligible;
  logic [FU_NUMBER-1:0]        sel_onehot;
  logic                        sel_found;
  fu_sel_t                     grant_fu;
  logic [ROB_INDEX_BITS-1:0]   grant_ticket;
  issue_hdr_t                  hdr_q;
  logic [ROB_INDEX_BITS-1:0]   ticket_q;

  // LSU is also blocked for one cycle after its own issue (shadow busy).
  always_comb begin
    eligible = '0;
    eligible[FU_LSU] = req_valid[FU_LSU] && !busy_fu[0] &&
                       !(hdr_q.valid && hdr_q.fu == FU_LSU);
    eligible[FU_CSR] = req_valid[FU_CSR] &&
                       (req_ticket[FU_CSR*ROB_INDEX_BITS +: ROB_INDEX_BITS] == rob_head);
    eligible[FU_ALU] = req_valid[FU_ALU] && !busy_fu[1];
    eligible[FU_BRU] = req_valid[FU_BRU];
    for (int unsigned i = 4; i < FU_NUMBER; i++) eligible[i] = req_valid[i];
  end

  oldest_select #(
    .N  (FU_NUMBER),
    .TW (ROB_INDEX_BITS)
  ) u_oldest_select (
    .valid  (eligible),
    .ticket (req_ticket),
    .head   (rob_head),
    .onehot (sel_onehot),
    .found  (sel_found)
  );

  assign grant = (rst_n && !flush && state == ARB_IDLE && sel_found) ? sel_onehot : '0;

  always_comb begin
    grant_fu     = '0;
    grant_ticket = '0;
    for (int unsigned i = 0; i < FU_NUMBER; i++) begin
      if (grant[i]) begin
        grant_fu     = fu_sel_t'(i);
        grant_ticket = req_ticket[i*ROB_INDEX_BITS +: ROB_INDEX_BITS];
      end
    end
  end

`ifdef EX_ARB_CSR_WATCHDOG_EN
  logic [7:0] wd_cnt;
  logic       wd_fire;

  assign wd_fire     = (state == ARB_CSR_WAIT) && !csr_done && (wd_cnt == 8'(CSR_TIMEOUT - 1));
  assign csr_timeout = wd_fire;

  // Counter is zero whenever we are not staying in CSR_WAIT, so entry starts at 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wd_cnt <= '0;
    end else if (state == ARB_CSR_WAIT && state_next == ARB_CSR_WAIT) begin
      wd_cnt <= wd_cnt + 8'd1;
    end else begin
      wd_cnt <= '0;
    end
  end
`else
  assign csr_timeout = 1'b0;
`endif

  always_comb begin
    state_next = state;
    unique case (state)
      ARB_IDLE: begin
        if (grant[FU_CSR]) state_next = ARB_CSR_WAIT;
      end
      ARB_CSR_WAIT: begin
        if (csr_done || flush) state_next = ARB_IDLE;
`ifdef EX_ARB_CSR_WATCHDOG_EN
        else if (wd_fire) state_next = ARB_IDLE;
`endif
      end
      default: state_next = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ARB_IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hdr_q    <= '0;
      ticket_q <= '0;
    end else begin
      hdr_q.valid <= |grant;
      if (|grant) begin
        hdr_q.fu <= grant_fu;
        ticket_q <= grant_ticket;
      end
    end
  end

  assign issue_valid  = hdr_q.valid;
  assign issue_fu     = hdr_q.fu;
  assign issue_ticket = ticket_q;

endmodule

// File: tb/tb_ex_issue_arbiter.sv
// Directed self-checking bench for ex_issue_arbiter (watchdog scenario follows EX_ARB_CSR_WATCHDOG_EN).
module tb_ex_issue_arbiter;

  logic        clk = 1'b0;
  logic        rst_n, flush, csr_done;
  logic [2:0]  rob_head;
  logic [3:0]  req_valid;
  logic [11:0] req_ticket;
  logic [1:0]  busy_fu;
  logic [3:0]  grant;
  logic        issue_valid;
  logic [1:0]  issue_fu;
  logic [2:0]  issue_ticket;
  logic        csr_timeout;

  int vectors = 0;
  int miscompares = 0;

  ex_issue_arbiter #(
    .FU_NUMBER      (4),
    .ROB_INDEX_BITS (3),
    .CSR_TIMEOUT    (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .rob_head     (rob_head),
    .req_valid    (req_valid),
    .req_ticket   (req_ticket),
    .busy_fu      (busy_fu),
    .csr_done     (csr_done),
    .grant        (grant),
    .issue_valid  (issue_valid),
    .issue_fu     (issue_fu),
    .issue_ticket (issue_ticket),
    .csr_timeout  (csr_timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] tk(input logic [2:0] t0, t1, t2, t3);
    return {t3, t2, t1, t0};
  endfunction

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    flush = 0; csr_done = 0; busy_fu = 2'b00; req_valid = 4'b0000; req_ticket = '0; rob_head = 3'd0;
  endtask

  task automatic test_reset;
    idle_inputs();
    rst_n = 0; req_valid = 4'hF;
    for (int k = 0; k < 2; k++) begin
      #1;
      vectors++; if (grant !== 4'b0000) begin miscompares++; $display("FAIL reset_grant got %b want 0000", grant); end
      cyc();
      vectors++; if (issue_valid !== 1'b0) begin miscompares++; $display("FAIL reset_issue_valid got %b want 0", issue_valid); end
      vectors++; if (issue_fu !== 2'd0 || issue_ticket !== 3'd0) begin miscompares++; $display("FAIL reset_hdr got fu=%0d tk=%0d want 0/0", issue_fu, issue_ticket); end
      vectors++; if (csr_timeout !== 1'b0) begin miscompares++; $display("FAIL reset_timeout got %b want 0", csr_timeout); end
    end
    rst_n = 1; req_valid = 4'b1000; req_ticket = tk(0, 0, 0, 2);
    #1;
    vectors++; if (grant !== 4'b1000) begin miscompares++; $display("FAIL post_reset_grant got %b want 1000", grant); end
    cyc();
    vectors++; if (issue_valid !== 1'b1 || issue_fu !== 2'd3 || issue_ticket !== 3'd2) begin miscompares++; $display("FAIL post_reset_issue got v=%b fu=%0d tk=%0d want 1/3/2", issue_valid, issue_fu, issue_ticket); end
    req_valid = 4'b0000;
    #1;
    vectors++; if (grant !== 4'b0000) begin miscompares++; $display("FAIL no_req_grant got %b want 0000", grant); end
    cyc();
    vectors++; if (issue_valid !== 1'b0) begin miscompares++; $display("FAIL no_req_issue got %b want 0", issue_valid); end
  endtask

  task automatic test_age;
    idle_inputs();
    rob_head = 3'd6; req_ticket = tk(0, 0, 7, 1); req_valid = 4'b1100;
    #1;
    vectors++; if (grant !== 4'b0100) begin miscompares++; $display("FAIL age_wrap_grant got %b want 0100", grant); end
    cyc();
    vectors++; if (issue_valid !== 1'b1 || issue_fu !== 2'd2 || issue_ticket !== 3'd7) begin miscompares++; $display("FAIL age_wrap_issue got v=%b fu=%0d tk=%0d want 1/2/7", issue_valid, issue_fu, issue_ticket); end
    rob_head = 3'd6; req_ticket = tk(0, 0, 2, 0);
    #1;
    vectors++; if (grant !== 4'b1000) begin miscompares++; $display("FAIL age_bru_older got %b want 1000", grant); end
    cyc();
    vectors++; if (issue_fu !== 2'd3 || issue_ticket !== 3'd0) begin miscompares++; $display("FAIL age_bru_issue got fu=%0d tk=%0d want 3/0", issue_fu, issue_ticket); end
    rob_head = 3'd0; req_ticket = tk(0, 0, 2, 2);
    #1;
    vectors++; if (grant !== 4'b0100) begin miscompares++; $display("FAIL age_tie got %b want 0100", grant); end
    cyc();
    req_valid = 4'b0000;
    cyc();
  endtask

  task automatic test_busy;
    idle_inputs();
    busy_fu = 2'b10; req_ticket = tk(0, 0, 2, 4); req_valid = 4'b1100;
    #1;
    vectors++; if (grant !== 4'b1000) begin miscompares++; $display("FAIL alu_busy got %b want 1000", grant); end
    cyc();
    busy_fu = 2'b01; req_ticket = tk(1, 0, 0, 0); req_valid = 4'b0001;
    #1;
    vectors++; if (grant !== 4'b0000) begin miscompares++; $display("FAIL lsu_busy got %b want 0000", grant); end
    cyc();
    busy_fu = 2'b00;
    #1;
    vectors++; if (grant !== 4'b0001) begin miscompares++; $display("FAIL lsu_grant got %b want 0001", grant); end
    cyc();
    vectors++; if (issue_valid !== 1'b1 || issue_fu !== 2'd0 || issue_ticket !== 3'd1) begin miscompares++; $display("FAIL lsu_issue got v=%b fu=%0d tk=%0d want 1/0/1", issue_valid, issue_fu, issue_ticket); end
    req_ticket = tk(2, 0, 0, 5); req_valid = 4'b1001;
    #1;
    vectors++; if (grant !== 4'b1000) begin miscompares++; $display("FAIL lsu_shadow got %b want 1000", grant); end
    cyc();
    vectors++; if (issue_fu !== 2'd3 || issue_ticket !== 3'd5) begin miscompares++; $display("FAIL shadow_bru_issue got fu=%0d tk=%0d want 3/5", issue_fu, issue_ticket); end
    req_valid = 4'b0001;
    #1;
    vectors++; if (grant !== 4'b0001) begin miscompares++; $display("FAIL lsu_after_shadow got %b want 0001", grant); end
    cyc();
    req_valid = 4'b0000;
    cyc();
  endtask

  task automatic test_csr_serialise;
    idle_inputs();
    rob_head = 3'd3; req_ticket = tk(0, 3, 4, 0); req_valid = 4'b0110;
    #1;
    vectors++; if (grant !== 4'b0010) begin miscompares++; $display("FAIL csr_grant got %b want 0010", grant); end
    cyc();
    vectors++; if (issue_valid !== 1'b1 || issue_fu !== 2'd1 || issue_ticket !== 3'd3) begin miscompares++; $display("FAIL csr_issue got v=%b fu=%0d tk=%0d want 1/1/3", issue_valid, issue_fu, issue_ticket); end
    req_valid = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      #1;
      vectors++; if (grant !== 4'b0000) begin miscompares++; $display("FAIL csr_wait_grant got %b want 0000", grant); end
      cyc();
      vectors++; if (issue_valid !== 1'b0) begin miscompares++; $display("FAIL csr_wait_issue got %b want 0", issue_valid); end
    end
    csr_done = 1;
    #1;
    vectors++; if (grant !== 4'b0000) begin miscompares++; $display("FAIL csr_done_cycle got %b want 0000", grant); end
    cyc();
    csr_done = 0;
    #1;
    vectors++; if (grant !== 4'b0100) begin miscompares++; $display("FAIL csr_resume got %b want 0100", grant); end
    cyc();
    vectors++; if (issue_fu !== 2'd2 || issue_ticket !== 3'd4) begin miscompares++; $display("FAIL csr_resume_issue got fu=%0d tk=%0d want 2/4", issue_fu, issue_ticket); end
    req_valid = 4'b0000;
    cyc();
  endtask

  task automatic test_flush;
    idle_inputs();
    rob_head = 3'd3; req_ticket = tk(0, 5, 6, 4); req_valid = 4'b0010;
    #1;
    vectors++; if (grant !== 4'b0000) begin miscompares++; $display("FAIL csr_spec got %b want 0000", grant); end
    req_valid = 4'b0110;
    #1;
    vectors++; if (grant !== 4'b0100) begin miscompares++; $display("FAIL csr_spec_alu got %b want 0100", grant); end
    cyc();
    req_ticket = tk(0, 3, 0, 4); req_valid = 4'b0010;
    cyc();
    flush = 1; req_valid = 4'b1000;
    #1;
    vectors++; if (grant !== 4'b0000) begin miscompares++; $display("FAIL flush_wait_grant got %b want 0000", grant); end
    cyc();
    flush = 0;
    vectors++; if (issue_valid !== 1'b0) begin miscompares++; $display("FAIL flush_issue got %b want 0", issue_valid); end
    #1;
    vectors++; if (grant !== 4'b1000) begin miscompares++; $display("FAIL flush_to_idle got %b want 1000", grant); end
    cyc();
    flush = 1;
    #1;
    vectors++; if (grant !== 4'b0000) begin miscompares++; $display("FAIL flush_idle_grant got %b want 0000", grant); end
    cyc();
    flush = 0;
    vectors++; if (issue_valid !== 1'b0) begin miscompares++; $display("FAIL flush_idle_issue got %b want 0", issue_valid); end
    req_valid = 4'b0010;
    cyc();
    flush = 1; csr_done = 1; req_valid = 4'b1000;
    cyc();
    flush = 0; csr_done = 0;
    #1;
    vectors++; if (grant !== 4'b1000) begin miscompares++; $display("FAIL flush_done_idle got %b want 1000", grant); end
    cyc();
    req_valid = 4'b0010;
    cyc();
    rst_n = 0; req_valid = 4'b0000;
    cyc();
    vectors++; if (issue_valid !== 1'b0) begin miscompares++; $display("FAIL rst_wait_issue got %b want 0", issue_valid); end
    rst_n = 1; csr_done = 1; req_valid = 4'b1000;
    #1;
    vectors++; if (grant !== 4'b1000) begin miscompares++; $display("FAIL rst_wait_idle got %b want 1000", grant); end
    cyc();
    csr_done = 0; req_valid = 4'b0000;
    cyc();
  endtask

  task automatic test_watchdog;
    logic exp_to;
    idle_inputs();
    rob_head = 3'd3; req_ticket = tk(0, 3, 0, 1); req_valid = 4'b0010;
    #1;
    vectors++; if (grant !== 4'b0010) begin miscompares++; $display("FAIL wd_csr_grant got %b want 0010", grant); end
    cyc();
    req_valid = 4'b1000;
`ifdef EX_ARB_CSR_WATCHDOG_EN
    for (int k = 1; k <= 8; k++) begin
      #1;
      exp_to = (k == 8);
      vectors++; if (csr_timeout !== exp_to) begin miscompares++; $display("FAIL wd_pulse cycle %0d got %b want %b", k, csr_timeout, exp_to); end
      vectors++; if (grant !== 4'b0000) begin miscompares++; $display("FAIL wd_wait_grant cycle %0d got %b want 0000", k, grant); end
      cyc();
    end
    #1;
    vectors++; if (csr_timeout !== 1'b0) begin miscompares++; $display("FAIL wd_after got %b want 0", csr_timeout); end
    vectors++; if (grant !== 4'b1000) begin miscompares++; $display("FAIL wd_idle_grant got %b want 1000", grant); end
`else
    exp_to = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      #1;
      vectors++; if (csr_timeout !== exp_to) begin miscompares++; $display("FAIL wd_off cycle %0d got %b want 0", k, csr_timeout); end
      vectors++; if (grant !== 4'b0000) begin miscompares++; $display("FAIL wd_off_grant cycle %0d got %b want 0000", k, grant); end
      cyc();
    end
    csr_done = 1;
    cyc();
    csr_done = 0;
    #1;
    vectors++; if (grant !== 4'b1000) begin miscompares++; $display("FAIL wd_off_resume got %b want 1000", grant); end
`endif
    cyc();
    req_valid = 4'b0000;
    cyc();
  endtask

  initial begin
    test_reset();
    test_age();
    test_busy();
    test_csr_serialise();
    test_flush();
    test_watchdog();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
